// File: rtl/stud_tone_analyzer.sv
// Rising-crossing tone analyzer: measures period, peak and trough of each cycle and reports lock.
// Define STUD_TONE_ANALYZER_PSC_EN to enable the psc_o prescaler estimate (otherwise psc_o is tied to 0).
module stud_tone_analyzer #(
    parameter int HYST    = 16,
    parameter int TIMEOUT = 2097152
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic signed [15:0] sample_i,
    input  logic               sample_valid_i,
    output logic        [21:0] period_o,
    output logic signed [15:0] peak_o,
    output logic signed [15:0] trough_o,
    output logic               result_valid_o,
    output logic               locked_o,
    output logic         [3:0] psc_o
);

    typedef enum logic {SEARCH, MEASURE} state_t;

    localparam logic signed [16:0] NEG_HYST    = -17'(HYST);
    localparam logic        [21:0] TIMEOUT_CNT = 22'(TIMEOUT);

    state_t             r_state;
    logic               r_armed;
    logic               r_havePrev;
    logic        [21:0] r_count;
    logic signed [15:0] r_max;
    logic signed [15:0] r_min;
    logic        [21:0] r_period;
    logic signed [15:0] r_peak;
    logic signed [15:0] r_trough;
    logic               r_resultValid;
    logic               r_locked;

    logic               w_below;
    logic               w_crossing;
    logic               w_publish;
    logic        [21:0] w_countNext;

    assign w_below     = $signed({sample_i[15], sample_i}) < NEG_HYST;
    assign w_crossing  = sample_valid_i && r_armed && !sample_i[15];
    assign w_publish   = w_crossing && (r_state == MEASURE);
    assign w_countNext = r_count + 22'd1;

    // The published period doubles as the "previous period" for the lock comparison.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= SEARCH;
            r_armed       <= 1'b0;
            r_havePrev    <= 1'b0;
            r_count       <= '0;
            r_max         <= '0;
            r_min         <= '0;
            r_period      <= '0;
            r_peak        <= '0;
            r_trough      <= '0;
            r_resultValid <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_resultValid <= 1'b0;
            if (sample_valid_i) begin
                if (w_crossing) begin
                    r_armed <= 1'b0;
                end else if (w_below) begin
                    r_armed <= 1'b1;
                end
                if (w_crossing) begin
                    if (r_state == MEASURE) begin
                        r_period      <= r_count;
                        r_peak        <= r_max;
                        r_trough      <= r_min;
                        r_resultValid <= 1'b1;
                        r_locked      <= r_havePrev && (r_count == r_period);
                        r_havePrev    <= 1'b1;
                    end
                    r_state <= MEASURE;
                    r_count <= 22'd1;
                    r_max   <= sample_i;
                    r_min   <= sample_i;
                end else if (r_state == MEASURE) begin
                    if (w_countNext >= TIMEOUT_CNT) begin
                        r_state    <= SEARCH;
                        r_armed    <= 1'b0;
                        r_locked   <= 1'b0;
                        r_havePrev <= 1'b0;
                        r_count    <= '0;
                        r_max      <= '0;
                        r_min      <= '0;
                    end else begin
                        r_count <= w_countNext;
                        if (sample_i > r_max) begin
                            r_max <= sample_i;
                        end
                        if (sample_i < r_min) begin
                            r_min <= sample_i;
                        end
                    end
                end
            end
        end
    end

`ifdef STUD_TONE_ANALYZER_PSC_EN
    function automatic logic [3:0] pscOf(input logic [21:0] p);
        logic [4:0] msb;
        msb = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (p[i]) begin
                msb = 5'(i);
            end
        end
        return (msb < 5'd6) ? 4'd0 : 4'(msb - 5'd6);
    endfunction

    logic [3:0] r_psc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_psc <= 4'd0;
        end else if (w_publish) begin
            r_psc <= pscOf(r_count);
        end
    end

    assign psc_o = r_psc;
`else
    assign psc_o = 4'd0;
`endif

    assign period_o       = r_period;
    assign peak_o         = r_peak;
    assign trough_o       = r_trough;
    assign result_valid_o = r_resultValid;
    assign locked_o       = r_locked;

endmodule

// File: tb/tb_stud_tone_analyzer.sv
// Self-checking bench for stud_tone_analyzer: directed and random stimulus against a window-queue model.
// The psc expectation follows STUD_TONE_ANALYZER_PSC_EN in the same way the design does.
module tb_stud_tone_analyzer;

    localparam int HYST    = 16;
    localparam int TIMEOUT = 256;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic signed [15:0] sample_i = '0;
    logic               sample_valid_i = 1'b0;
    logic        [21:0] period_o;
    logic signed [15:0] peak_o;
    logic signed [15:0] trough_o;
    logic               result_valid_o;
    logic               locked_o;
    logic         [3:0] psc_o;

    stud_tone_analyzer #(.HYST(HYST), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .period_o       (period_o),
        .peak_o         (peak_o),
        .trough_o       (trough_o),
        .result_valid_o (result_valid_o),
        .locked_o       (locked_o),
        .psc_o          (psc_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cycleNum = 0;
    int lastPulse = -1;

    // Model: the open window is simply the list of samples consumed since its opening crossing.
    logic signed [15:0] win[$];
    bit                 mOpen;
    bit                 mArmed;
    bit                 mHavePrev;
    int                 mPrev;
    logic               expRv;
    logic        [21:0] expPeriod;
    logic signed [15:0] expPeak;
    logic signed [15:0] expTrough;
    logic               expLocked;
    logic         [3:0] expPsc;

    function automatic logic [3:0] expectedPsc(input int p);
`ifdef STUD_TONE_ANALYZER_PSC_EN
        int lg;
        lg = $clog2(p + 1) - 1;
        if (lg < 6) return 4'd0;
        if (lg - 6 > 15) return 4'd15;
        return 4'(lg - 6);
`else
        return 4'd0;
`endif
    endfunction

    task automatic modelReset();
        win.delete();
        mOpen = 0; mArmed = 0; mHavePrev = 0; mPrev = 0;
        expRv = 0; expPeriod = '0; expPeak = '0; expTrough = '0; expLocked = 0; expPsc = '0;
    endtask

    task automatic stepModel(input bit valid, input logic signed [15:0] s);
        bit crossing;
        logic signed [15:0] hi;
        logic signed [15:0] lo;
        expRv = 0;
        if (!valid) return;
        crossing = mArmed && (s >= 0);
        if (crossing) mArmed = 0;
        else if (int'(s) < -HYST) mArmed = 1;
        if (crossing) begin
            if (mOpen) begin
                hi = win[0];
                lo = win[0];
                foreach (win[i]) begin
                    if (win[i] > hi) hi = win[i];
                    if (win[i] < lo) lo = win[i];
                end
                expRv     = 1;
                expPeriod = 22'(win.size());
                expPeak   = hi;
                expTrough = lo;
                expLocked = mHavePrev && (win.size() == mPrev);
                expPsc    = expectedPsc(win.size());
                mPrev     = win.size();
                mHavePrev = 1;
            end
            win.delete();
            win.push_back(s);
            mOpen = 1;
        end else if (mOpen) begin
            win.push_back(s);
            if (win.size() >= TIMEOUT) begin
                win.delete();
                mOpen = 0; mArmed = 0; mHavePrev = 0; expLocked = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (result_valid_o === expRv) else begin
            errors++; $error("FAIL %s result_valid observed=%0b expected=%0b", tag, result_valid_o, expRv);
        end
        checks++;
        assert (period_o === expPeriod) else begin
            errors++; $error("FAIL %s period observed=%0d expected=%0d", tag, period_o, expPeriod);
        end
        checks++;
        assert (peak_o === expPeak) else begin
            errors++; $error("FAIL %s peak observed=%0d expected=%0d", tag, peak_o, expPeak);
        end
        checks++;
        assert (trough_o === expTrough) else begin
            errors++; $error("FAIL %s trough observed=%0d expected=%0d", tag, trough_o, expTrough);
        end
        checks++;
        assert (locked_o === expLocked) else begin
            errors++; $error("FAIL %s locked observed=%0b expected=%0b", tag, locked_o, expLocked);
        end
        checks++;
        assert (psc_o === expPsc) else begin
            errors++; $error("FAIL %s psc observed=%0d expected=%0d", tag, psc_o, expPsc);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic signed [15:0] s, input string tag);
        sample_valid_i = valid;
        sample_i       = s;
        stepModel(valid, s);
        @(posedge clk_i);
        #1;
        cycleNum++;
        checkOutput(tag);
    endtask

    task automatic applyReset();
        #1 rst_i = 1'b1;
        #1;
        modelReset();
        checkOutput("reset");
        #1 rst_i = 1'b0;
    endtask

    function automatic logic signed [15:0] sineAt(input int n, input int p);
        real v;
        v = 20000.0 * $sin(2.0 * 3.14159265358979 * real'(n) / real'(p));
        return 16'($rtoi(v));
    endfunction

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++; $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        modelReset();
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_hold");
        rst_i = 1'b0;

        for (int n = 0; n < 64 * 6; n++) applyStimulus(1, sineAt(n + 7, 64), "sine64");
        checkValue("sine64_period", int'(period_o), 64);
        checkValue("sine64_locked", int'(locked_o), 1);

        for (int n = 0; n < 300; n++) applyStimulus(1, 16'sd0, "timeout");
        checkValue("timeout_locked", int'(locked_o), 0);
        checkValue("timeout_period_held", int'(period_o), 64);

        for (int n = 0; n < 64 * 2 + 20; n++) applyStimulus(1, sineAt(n, 64), "sine_pre_rst");
        applyReset();
        for (int n = 0; n < 64 * 3; n++) applyStimulus(1, sineAt(n + 30, 64), "sine_post_rst");
        checkValue("post_rst_period", int'(period_o), 64);

        applyReset();
        lastPulse = -1;
        for (int k = 0; k < 20 * 6; k++) begin
            applyStimulus(1, ((k % 20) < 10) ? -16'sd100 : 16'sd200, "square");
            if (result_valid_o === 1'b1) begin
                if (lastPulse >= 0) checkValue("square_spacing", cycleNum - lastPulse, 40);
                lastPulse = cycleNum;
            end
            applyStimulus(0, 16'($urandom), "square_gap");
        end
        checkValue("square_period", int'(period_o), 20);
        checkValue("square_peak", int'(peak_o), 200);
        checkValue("square_trough", int'(trough_o), -100);

        applyReset();
        for (int k = 0; k < 200; k++) applyStimulus(1, (k % 2) ? 16'sd10 : -16'sd10, "small_osc");
        checkValue("small_osc_locked", int'(locked_o), 0);
        checkValue("small_osc_period", int'(period_o), 0);

        for (int r = 0; r < 6; r++) begin
            int p;
            p = int'($urandom_range(70, 250));
            for (int n = 0; n < p * 3; n++)
                applyStimulus($urandom_range(0, 4) != 0, sineAt(n, p), "rand_sine");
        end
        for (int k = 0; k < 2000; k++)
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), "rand_samples");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
